// File: rtl/proc_core_pkg.sv
// ============================================================================
// Module : proc_core_pkg
// Brief  : Shared types, encodings and decode helper for the proc_core pipeline
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package proc_core_pkg;

    localparam int DATA_W = 36;
    localparam int NREG   = 32;
    localparam int REG_W  = 5;

    localparam logic [31:0] NOP_WORD = 32'h0200_0000;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 25;
    localparam int RD_MSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RA_MSB  = 19;
    localparam int RA_LSB  = 15;
    localparam int RB_MSB  = 14;
    localparam int RB_LSB  = 10;
    localparam int IMM15_W = 15;
    localparam int IMM18_W = 18;

    typedef enum logic [6:0] {
        OP_ADD  = 7'h00,
        OP_NOP  = 7'h01,
        OP_SUB  = 7'h08,
        OP_AND  = 7'h09,
        OP_OR   = 7'h0A,
        OP_XOR  = 7'h0B,
        OP_SHL  = 7'h0C,
        OP_SHR  = 7'h0D,
        OP_ADDI = 7'h10,
        OP_LIL  = 7'h11,
        OP_LIH  = 7'h12
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_LIL = 4'd7,
        ALU_LIH = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_S15  = 2'd1,
        IMM_U18  = 2'd2
    } imm_kind_e;

    typedef struct packed {
        logic             wr_en;
        alu_op_e          alu_op;
        logic             use_imm;
        imm_kind_e        imm_kind;
        logic [REG_W-1:0] rd;
        logic             undef;
    } ctrl_t;

    typedef struct packed {
        logic              wr_en;
        alu_op_e           alu_op;
        logic [REG_W-1:0]  rd;
        logic              undef;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } ex_stage_t;

    typedef struct packed {
        logic              wr_en;
        logic [REG_W-1:0]  rd;
        logic              undef;
        logic [DATA_W-1:0] data;
    } mem_stage_t;

    typedef struct packed {
        logic              wr_en;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_stage_t;

    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t c;
        c.wr_en    = 1'b1;
        c.alu_op   = ALU_ADD;
        c.use_imm  = 1'b0;
        c.imm_kind = IMM_NONE;
        c.rd       = inst[RD_MSB:RD_LSB];
        c.undef    = 1'b0;
        case (inst[OP_MSB:OP_LSB])
            OP_ADD:  c.alu_op = ALU_ADD;
            OP_SUB:  c.alu_op = ALU_SUB;
            OP_AND:  c.alu_op = ALU_AND;
            OP_OR:   c.alu_op = ALU_OR;
            OP_XOR:  c.alu_op = ALU_XOR;
            OP_SHL:  c.alu_op = ALU_SHL;
            OP_SHR:  c.alu_op = ALU_SHR;
            OP_ADDI: begin
                c.use_imm  = 1'b1;
                c.imm_kind = IMM_S15;
            end
            OP_LIL: begin
                c.alu_op   = ALU_LIL;
                c.use_imm  = 1'b1;
                c.imm_kind = IMM_U18;
            end
            OP_LIH: begin
                c.alu_op   = ALU_LIH;
                c.use_imm  = 1'b1;
                c.imm_kind = IMM_U18;
            end
            OP_NOP:  c.wr_en = 1'b0;
            default: begin
                c.wr_en = 1'b0;
                c.undef = 1'b1;
            end
        endcase
        // Non-writing slots carry a zero index so writeback outputs stay clean.
        if (!c.wr_en) begin
            c.rd = '0;
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/proc_core_alu.sv
// ============================================================================
// Module : proc_core_alu
// Brief  : Combinational 36-bit ALU (add/sub/logic/shift/immediate merge)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module proc_core_alu
    import proc_core_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] result_o
);

    logic [5:0] w_shamt;
    logic       w_shift_oor;

    assign w_shamt     = b_i[5:0];
    assign w_shift_oor = (w_shamt >= 6'(DATA_W));

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SHL: result_o = w_shift_oor ? '0 : (a_i << w_shamt);
            ALU_SHR: result_o = w_shift_oor ? '0 : (a_i >> w_shamt);
            // a carries the old rD for the immediate-merge forms
            ALU_LIL: result_o = {a_i[DATA_W-1:IMM18_W], b_i[IMM18_W-1:0]};
            ALU_LIH: result_o = {b_i[DATA_W-IMM18_W-1:0], a_i[IMM18_W-1:0]};
            default: result_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/proc_core.sv
// ============================================================================
// Module : proc_core
// Brief  : 5-stage in-order scalar pipeline (F/D/E/M/W), 36-bit, 32 registers.
//          Define PROC_CORE_FWD_EN to forward M/W results into Execute.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module proc_core
    import proc_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_f,
    output logic              wb_en,
    output logic [4:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    logic [31:0]       f_inst_q;
    logic [31:0]       d_inst_q;
    ex_stage_t         ex_q, ex_d;
    mem_stage_t        mem_q, mem_d;
    wb_stage_t         wb_q, wb_d;
    logic              err_q;
    logic [DATA_W-1:0] rf_q [NREG];

    ctrl_t             w_ctrl;
    logic [REG_W-1:0]  w_src_a;
    logic [REG_W-1:0]  w_src_b;
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu_res;

    // Decode: lil/lih read their own destination as operand a.
    always_comb begin
        w_ctrl  = decode(d_inst_q);
        w_src_b = d_inst_q[RB_MSB:RB_LSB];
        w_src_a = d_inst_q[RA_MSB:RA_LSB];
        if (w_ctrl.alu_op == ALU_LIL || w_ctrl.alu_op == ALU_LIH) begin
            w_src_a = d_inst_q[RD_MSB:RD_LSB];
        end
        if (w_ctrl.imm_kind == IMM_S15) begin
            w_imm = {{(DATA_W-IMM15_W){d_inst_q[IMM15_W-1]}}, d_inst_q[IMM15_W-1:0]};
        end else begin
            w_imm = {{(DATA_W-IMM18_W){1'b0}}, d_inst_q[IMM18_W-1:0]};
        end
    end

    assign w_rf_a = (wb_q.wr_en && wb_q.rd == w_src_a) ? wb_q.data : rf_q[w_src_a];
    assign w_rf_b = (wb_q.wr_en && wb_q.rd == w_src_b) ? wb_q.data : rf_q[w_src_b];

    always_comb begin
        ex_d.wr_en  = w_ctrl.wr_en;
        ex_d.alu_op = w_ctrl.alu_op;
        ex_d.rd     = w_ctrl.rd;
        ex_d.undef  = w_ctrl.undef;
        ex_d.a      = w_rf_a;
        ex_d.b      = w_ctrl.use_imm ? w_imm : w_rf_b;
    end

`ifdef PROC_CORE_FWD_EN
    logic [REG_W-1:0] fwd_a_idx_q;
    logic [REG_W-1:0] fwd_b_idx_q;
    logic             fwd_b_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_idx_q <= '0;
            fwd_b_idx_q <= '0;
            fwd_b_en_q  <= 1'b0;
        end else begin
            fwd_a_idx_q <= w_src_a;
            fwd_b_idx_q <= w_src_b;
            fwd_b_en_q  <= !w_ctrl.use_imm;
        end
    end

    // Memory is younger than Writeback, so it wins when both match.
    always_comb begin
        w_op_a = ex_q.a;
        if (mem_q.wr_en && mem_q.rd == fwd_a_idx_q) begin
            w_op_a = mem_q.data;
        end else if (wb_q.wr_en && wb_q.rd == fwd_a_idx_q) begin
            w_op_a = wb_q.data;
        end
        w_op_b = ex_q.b;
        if (fwd_b_en_q && mem_q.wr_en && mem_q.rd == fwd_b_idx_q) begin
            w_op_b = mem_q.data;
        end else if (fwd_b_en_q && wb_q.wr_en && wb_q.rd == fwd_b_idx_q) begin
            w_op_b = wb_q.data;
        end
    end
`else
    assign w_op_a = ex_q.a;
    assign w_op_b = ex_q.b;
`endif

    proc_core_alu u_alu (
        .a_i      (w_op_a),
        .b_i      (w_op_b),
        .op_i     (ex_q.alu_op),
        .result_o (w_alu_res)
    );

    always_comb begin
        mem_d.wr_en = ex_q.wr_en;
        mem_d.rd    = ex_q.rd;
        mem_d.undef = ex_q.undef;
        mem_d.data  = ex_q.wr_en ? w_alu_res : '0;
    end

    always_comb begin
        wb_d.wr_en = mem_q.wr_en;
        wb_d.rd    = mem_q.rd;
        wb_d.data  = mem_q.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_inst_q <= NOP_WORD;
            d_inst_q <= NOP_WORD;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            f_inst_q <= inst_f;
            d_inst_q <= f_inst_q;
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            // err rises in the cycle the undefined op occupies Writeback
            err_q    <= err_q | mem_q.undef;
            if (wb_q.wr_en) begin
                rf_q[wb_q.rd] <= wb_q.data;
            end
        end
    end

    assign wb_en   = wb_q.wr_en;
    assign wb_reg  = wb_q.rd;
    assign wb_data = wb_q.data;
    assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_proc_core.sv
// ============================================================================
// Module : tb_proc_core
// Brief  : Scoreboard bench for proc_core with directed instruction vectors
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_proc_core;

    logic        clk;
    logic        rst;
    logic [31:0] inst_f;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [35:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [35:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    localparam logic [31:0] NOP = 32'h0200_0000;

    proc_core dut (
        .clk     (clk),
        .rst     (rst),
        .inst_f  (inst_f),
        .wb_en   (wb_en),
        .wb_reg  (wb_reg),
        .wb_data (wb_data),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 10'b0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] ra, input logic [14:0] imm);
        return {op, rd, ra, imm};
    endfunction

    function automatic logic [31:0] enc_l(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [17:0] imm);
        return {op, rd, 2'b00, imm};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Drive one instruction; called and returns on a falling edge.
    task automatic issue(input logic [31:0] w);
        inst_f = w;
        @(negedge clk);
    endtask

    task automatic issue_exp(input logic [31:0] w, input logic [4:0] rd, input logic [35:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
        issue(w);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(NOP);
    endtask

    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got reg %0d data %0h expected no writeback", wb_reg, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_reg", 64'(wb_reg), 64'(mon_e.rd));
                check("wb_data", 64'(wb_data), 64'(mon_e.data));
            end
        end else begin
            check("idle_zero", 64'({wb_reg, wb_data}), 64'd0);
        end
    end

    initial begin
        rst    = 1'b1;
        inst_f = NOP;
        repeat (3) @(negedge clk);
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_wb_reg", 64'(wb_reg), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // Latency: result appears exactly four edges after the sampling edge.
        issue_exp(enc_l(7'h11, 5'd1, 18'h3FFFF), 5'd1, 36'h0_0003_FFFF);
        nops(3);
        check("lat_early", 64'(wb_en), 64'd0);
        nops(1);
        check("lat_wb_en", 64'(wb_en), 64'd1);
        check("lat_wb_reg", 64'(wb_reg), 64'd1);

        issue_exp(enc_l(7'h11, 5'd2, 18'd5), 5'd2, 36'd5);
        issue_exp(enc_l(7'h11, 5'd3, 18'd7), 5'd3, 36'd7);
        nops(2);
        issue_exp(enc_r(7'h00, 5'd4, 5'd2, 5'd3), 5'd4, 36'd12);
        issue_exp(enc_r(7'h08, 5'd6, 5'd5, 5'd2), 5'd6, 36'hF_FFFF_FFFB);
        issue_exp(enc_r(7'h0B, 5'd7, 5'd2, 5'd3), 5'd7, 36'd2);
        issue_exp(enc_r(7'h09, 5'd11, 5'd2, 5'd3), 5'd11, 36'd5);
        issue_exp(enc_r(7'h0A, 5'd12, 5'd2, 5'd3), 5'd12, 36'd7);
        issue_exp(enc_i(7'h10, 5'd13, 5'd2, 15'h7FFA), 5'd13, 36'hF_FFFF_FFFF);
        issue(NOP);
        issue_exp(enc_l(7'h12, 5'd1, 18'h2_0001), 5'd1, 36'h8_0007_FFFF);

        issue_exp(enc_l(7'h11, 5'd9, 18'd40), 5'd9, 36'd40);
        nops(2);
        issue_exp(enc_r(7'h0C, 5'd8, 5'd2, 5'd9), 5'd8, 36'd0);
        issue_exp(enc_r(7'h0D, 5'd10, 5'd3, 5'd9), 5'd10, 36'd0);
        issue_exp(enc_l(7'h11, 5'd9, 18'd1), 5'd9, 36'd1);
        nops(2);
        issue_exp(enc_r(7'h0C, 5'd8, 5'd2, 5'd9), 5'd8, 36'd10);
        issue_exp(enc_r(7'h0D, 5'd10, 5'd3, 5'd9), 5'd10, 36'd3);
        issue_exp(enc_l(7'h11, 5'd14, 18'd35), 5'd14, 36'd35);
        nops(2);
        issue_exp(enc_r(7'h0C, 5'd15, 5'd2, 5'd14), 5'd15, 36'h8_0000_0000);

        // Undefined opcode: no writeback, sticky error.
        issue({7'h7F, 25'd0});
        nops(5);
        check("err_set", 64'(err), 64'd1);
        issue_exp(enc_i(7'h10, 5'd16, 5'd2, 15'd1), 5'd16, 36'd6);
        nops(5);
        check("err_sticky", 64'(err), 64'd1);

        // Reset while an add sits in Execute: it must never write back.
        issue(enc_r(7'h00, 5'd4, 5'd2, 5'd3));
        nops(2);
        rst = 1'b1;
        issue(NOP);
        check("rst_mid_wb_en", 64'(wb_en), 64'd0);
        check("rst_mid_err", 64'(err), 64'd0);
        rst = 1'b0;
        issue_exp(enc_r(7'h00, 5'd4, 5'd2, 5'd3), 5'd4, 36'd0);
        issue_exp(enc_r(7'h0A, 5'd20, 5'd3, 5'd31), 5'd20, 36'd0);
        issue_exp(enc_i(7'h10, 5'd21, 5'd1, 15'd0), 5'd21, 36'd0);
        nops(4);

        // Back-to-back dependency.
        issue_exp(enc_l(7'h11, 5'd1, 18'd3), 5'd1, 36'd3);
        nops(2);
        issue_exp(enc_r(7'h00, 5'd1, 5'd1, 5'd1), 5'd1, 36'd6);
`ifdef PROC_CORE_FWD_EN
        issue_exp(enc_r(7'h00, 5'd1, 5'd1, 5'd1), 5'd1, 36'd12);
`else
        issue_exp(enc_r(7'h00, 5'd1, 5'd1, 5'd1), 5'd1, 36'd6);
`endif
        nops(6);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("final_err", 64'(err), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/proc_core.md
Name: proc_core

Overview:
- Minimal 5-stage in-order scalar pipeline: Fetch, Decode, Execute, Memory, Writeback.
- Core of the processor, driven by an externally supplied instruction word each cycle. There is no internal instruction memory.
- 36-bit scalar datapath with a 32x36 register file.
- Writeback is exposed on ports so a trace checker can compare each instruction's result against a golden trace.

Parameters:
- DATA_W, 36, scalar register/datapath width.
- NREG, 32, number of scalar registers (5-bit index).
- NOP_WORD, 32'h0200_0000, canonical no-operation encoding.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- inst_f  in  32  instruction entering Fetch this cycle.
- wb_en  out  1  scalar register write occurring this cycle.
- wb_reg  out  5  destination register index being written.
- wb_data  out  DATA_W  value being written.
- err  out  1  sticky undefined-opcode flag.

Behaviour:
- Encoding: op=[31:25], rD=[24:20], rA=[19:15], rB=[14:10], imm15=[14:0] (sign-extended), imm18=[17:0].
- R-type ops: 7'h00 add; 7'h08 sub (rA-rB); 7'h09 and; 7'h0A or; 7'h0B xor.
- Shift ops: 7'h0C shl; 7'h0D shr logical. Shift amount is rB[5:0]; an amount >=36 gives 0.
- 7'h01 nop: no write.
- 7'h10 addi: rD = rA + sext(imm15).
- 7'h11 lil: rD = {rD[35:18], imm18}, i.e. old rD is read in Decode.
- 7'h12 lih: rD = {imm18, rD[17:0]}.
- Arithmetic wraps modulo 2^36; no flags.
- Any other opcode behaves as nop and sets err. err stays set until rst.
- Latency: an instruction sampled on inst_f at edge N produces wb_en/wb_reg/wb_data during the cycle following edge N+4. This matches one instruction plus 4 nops observed 4 edges later.
- The register file is written at the end of that Writeback cycle.
- Register file reads in Decode are combinational, with write-through bypass: a same-cycle Writeback to the register being read is returned to Decode.
- No hazard detection and no stalls (without the optional feature). Software must place a dependent instruction at least 3 slots after its producer.
- r0 is an ordinary register (writable).
- wb_en=0 for nop and undefined opcodes. When wb_en=0, wb_reg and wb_data are 0.
- Reset: all pipeline stage registers load NOP_WORD-equivalent control and 0 data; all registers clear to 0; wb_en=0, wb_reg=0, wb_data=0, err=0.
- Reset asserted mid-stream discards all in-flight instructions; no writeback occurs for them.
- inst_f sampled during the rst=1 cycle is discarded.

Optional Feature:
- Macro: PROC_CORE_FWD_EN.
- Defined: Execute operands are forwarded from the Memory and Writeback stages, Memory taking priority, when the source rD matches and that stage writes. Back-to-back dependent instructions then produce correct results with no nops.
- Undefined: no forwarding logic; the 3-slot spacing rule applies.
- Without forwarding, a dependent instruction issued too early reads the stale register value (deterministic, not flagged).

Decomposition:
- Package proc_core_pkg holds:
  - the opcode enum and NOP_WORD;
  - DATA_W;
  - field-position localparams;
  - a decoded-control struct (wr_en, alu_op, use_imm, imm_kind, rD);
  - per-stage pipeline register structs.
- One natural sub-module: proc_core_alu, combinational (a, b, op -> result).

Test Plan:
- lil r1,0x3FFFF; 4 nops -> after 4 edges: wb_en=1, wb_reg=1, wb_data=36'h0_0003_FFFF.
- Preload r2=5, r3=7 via lil and spacing; add r4,r2,r3 -> wb_reg=4, wb_data=12.
- Wrap and logic checks, r5=0:
  - sub r6,r5,r2 -> 36'hF_FFFF_FFFB.
  - xor r7,r2,r3 -> 2.
- shl r8,r2,r9 with r9=40 -> 0; with r9=1 -> 10.
- Opcode 7'h7F -> err=1, wb_en=0. err remains 1 through later valid instructions and clears only on rst.
- rst asserted while add is in Execute -> no writeback for it; wb_en=0; all registers read 0 afterwards.
- Back-to-back add r1,r1,r1 twice, r1=3:
  - with PROC_CORE_FWD_EN -> 6 then 12;
  - without it -> 6 then 6.
